// File: rtl/bp_nonsynth_io_cfg_responder_if.sv
// io_cmd / io_resp channel bundle between a host loader (master) and the
// config-space responder (slave).
interface bp_nonsynth_io_cfg_responder_if #(
  parameter int msg_width_p = 127
);
  // Handshake rules:
  //  - A command transfers on a cycle where io_cmd_v_i and io_cmd_yumi_o are
  //    both high. yumi is a same-cycle consume, so it may depend on valid.
  //  - A response transfers on a cycle where io_resp_v_o and io_resp_ready_i
  //    are both high. Once raised, valid and the payload stay stable until
  //    that transfer happens.
  logic [msg_width_p-1:0] io_cmd_i;
  logic                   io_cmd_v_i;
  logic                   io_cmd_yumi_o;
  logic [msg_width_p-1:0] io_resp_o;
  logic                   io_resp_v_o;
  logic                   io_resp_ready_i;

  modport master (
    output io_cmd_i, io_cmd_v_i, io_resp_ready_i,
    input  io_cmd_yumi_o, io_resp_o, io_resp_v_o
  );

  modport slave (
    input  io_cmd_i, io_cmd_v_i, io_resp_ready_i,
    output io_cmd_yumi_o, io_resp_o, io_resp_v_o
  );
endinterface

// File: rtl/bp_nonsynth_io_cfg_responder.sv
// Io-side endpoint that answers uncached config-space commands: owns the
// per-core freeze register and returns exactly one response per command.
module bp_nonsynth_io_cfg_responder #(
  parameter int num_core_p    = 4,
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64,
  parameter int resp_delay_p  = 0,
  parameter int err_width_p   = 8,
  parameter int msg_width_lp  = 4 + paddr_width_p + 3 + 16 + data_width_p
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_nonsynth_io_cfg_responder_if.slave io,
  output logic [num_core_p-1:0]  freeze_o,
  output logic [err_width_p-1:0] err_count_o,
  output logic [1:0]             state_o
);

  // Message layout, LSB first: msg_type[4], addr[paddr], size[3],
  // payload[16], data[data_width]. The header is everything below data.
  localparam int hdr_width_lp = 23 + paddr_width_p;
  localparam int addr_lsb_lp  = 4;

  localparam logic [3:0]  e_cce_mem_uc_rd      = 4'h2;
  localparam logic [3:0]  e_cce_mem_uc_wr      = 4'h3;
  localparam logic [3:0]  cfg_dev_gp           = 4'h2;
  localparam logic [19:0] bp_cfg_reg_freeze_gp = 20'h00008;

  localparam logic [7:0] delay_init_lp =
    (resp_delay_p > 0) ? 8'(resp_delay_p - 1) : 8'd0;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_wait = 2'd1,
    e_resp = 2'd2
  } state_e;

  state_e                  state_r;
  logic [msg_width_lp-1:0] cmd_r;
  logic                    resp_bit_r;
  logic [7:0]              cnt_r;

  // Address viewed as a local address: reg[19:0], dev[23:20], cce[30:24],
  // and every bit above that forms the nonlocal field.
  logic [3:0]               cmd_type;
  logic [paddr_width_p-1:0] cmd_addr;
  logic                     cmd_data0;
  logic                     cmd_nonlocal;
  logic [6:0]               cmd_cce;
  logic [num_core_p-1:0]    cce_onehot;
  logic                     cce_hit, is_rd, is_wr, mapped, cur_bit, accept;

  assign cmd_type     = io.io_cmd_i[3:0];
  assign cmd_addr     = io.io_cmd_i[addr_lsb_lp +: paddr_width_p];
  assign cmd_data0    = io.io_cmd_i[hdr_width_lp];
  assign cmd_nonlocal = |cmd_addr[paddr_width_p-1:31];
  assign cmd_cce      = cmd_addr[30:24];

  always_comb begin
    cce_onehot = '0;
    for (int i = 0; i < num_core_p; i++) begin
      cce_onehot[i] = (cmd_cce == 7'(i));
    end
  end

  assign cce_hit = |cce_onehot;
  assign is_rd   = (cmd_type == e_cce_mem_uc_rd);
  assign is_wr   = (cmd_type == e_cce_mem_uc_wr);
  assign mapped  = !cmd_nonlocal && (cmd_addr[23:20] == cfg_dev_gp)
                && (cmd_addr[19:0] == bp_cfg_reg_freeze_gp)
                && cce_hit && (is_rd || is_wr);
  assign cur_bit = |(freeze_o & cce_onehot);
  assign accept  = (state_r == e_idle) && io.io_cmd_v_i;

  assign io.io_cmd_yumi_o = accept;
  assign io.io_resp_v_o   = (state_r == e_resp);
  assign io.io_resp_o     = {{(data_width_p-1){1'b0}}, resp_bit_r,
                             cmd_r[hdr_width_lp-1:0]};
  assign state_o          = state_r;

  // Command data is consumed at accept; the latched copy is kept whole for
  // debug visibility but only its header feeds the response.
  logic unused_cmd_data;
  assign unused_cmd_data = ^cmd_r[msg_width_lp-1:hdr_width_lp];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      cmd_r       <= '0;
      resp_bit_r  <= 1'b0;
      cnt_r       <= '0;
      freeze_o    <= '1;
      err_count_o <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (accept) begin
            cmd_r      <= io.io_cmd_i;
            cnt_r      <= delay_init_lp;
            resp_bit_r <= mapped && is_rd && cur_bit;
            if (mapped && is_wr) begin
              freeze_o <= cmd_data0 ? (freeze_o | cce_onehot)
                                    : (freeze_o & ~cce_onehot);
            end
            if (!mapped && (err_count_o != '1)) begin
              err_count_o <= err_count_o + 1'b1;
            end
            state_r <= (resp_delay_p > 0) ? e_wait : e_resp;
          end
        end
        e_wait: begin
          if (cnt_r == 8'd0) state_r <= e_resp;
          else               cnt_r   <= cnt_r - 8'd1;
        end
        e_resp: begin
          if (io.io_resp_ready_i) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule
